waveform_analyzer: RTL and testbench
====================================

WAVEFORM_ANALYZER -- requirements
Module: waveform_analyzer

Interface
REQ-001 SHALL have parameter PER_WIDTH, default 16, width of period, high-count and timeout counters.
REQ-002 SHALL have parameter HYST, default 0, non-negative crossing hysteresis in LSBs.
REQ-003 SHALL have port clk, input, 1, rising-edge system clock.
REQ-004 SHALL have port rst_n, input, 1; reset rst_n, synchronous, active-low.
REQ-005 SHALL have port enable, input, 1; 0 forces IDLE.
REQ-006 SHALL have port sample_i, input, LUT_WIDTH signed; sample under analysis.
REQ-007 SHALL have port sample_valid_i, input, 1; sample_i accepted on a clk edge when high.
REQ-008 SHALL have port period_o, output, PER_WIDTH; samples per measured cycle.
REQ-009 SHALL have port high_cnt_o, output, PER_WIDTH; samples in the cycle with sample >= 0.
REQ-010 SHALL have ports max_o and min_o, output, LUT_WIDTH signed; peak values in the cycle.
REQ-011 SHALL have port result_valid_o, output, 1; one-cycle pulse when the result outputs update.
REQ-012 SHALL have port timeout_o, output, 1; one-cycle pulse when the period counter saturates.
REQ-013 SHALL have port locked_o, output, 1; high while in MEASURE.

Function
REQ-014 SHALL run an FSM with states IDLE, SEEK and MEASURE.
REQ-015 SHALL go IDLE->SEEK when enable=1, and any state->IDLE on the cycle after enable=0.
REQ-016 SHALL set an internal "below" flag on an accepted sample < -HYST and clear it when a rising crossing is detected.
REQ-017 SHALL define a rising crossing as an accepted sample >= HYST while "below" is set.
REQ-018 SHALL, in SEEK, go to MEASURE on the first rising crossing and open a window at that sample, emitting no result.
REQ-019 SHALL define the window as the crossing sample inclusive through the next crossing sample exclusive.
REQ-020 SHALL, per accepted sample in the window, increment the period count, increment the high count if sample >= 0, and track max and min.
REQ-021 SHALL, on a rising crossing in MEASURE, register the closed window's period, high count, max and min to the outputs and pulse result_valid_o on the next cycle (latency 1).
REQ-022 SHALL, on the same edge, reopen the window with period=1, high=1 (crossing sample >= 0), and max=min=the crossing sample.
REQ-023 SHALL ignore the inputs while sample_valid_i=0 and change no counters.
REQ-024 SHALL, when the period count reaches 2^PER_WIDTH-1 without a crossing, pulse timeout_o, go to SEEK, and leave the result outputs unchanged.
REQ-025 SHALL hold the result outputs between result_valid_o pulses.
REQ-026 SHALL keep locked_o = (state == MEASURE), registered.

Reset
REQ-027 SHALL, while rst_n=0 on a clk edge, set state=IDLE, clear "below", zero all counters, period_o, high_cnt_o, max_o and min_o, and drive result_valid_o, timeout_o and locked_o to 0.
REQ-028 SHALL discard a partially measured window on reset asserted mid-measurement, and emit no result for it.

Structure
REQ-029 SHALL add the state enum ana_state_t (IDLE, SEEK, MEASURE) to waveform_gen_pkg, and reuse LUT_WIDTH from that package.
REQ-030 SHALL place the hysteresis/"below" logic in the sub-module zc_detect, with outputs rise_o and below_o.

Verification
REQ-031 SHALL cover this case: LUT_WIDTH=8, HYST=0, square wave with 6 samples at +100 and 4 at -100, continuous valid -> from the second crossing, period_o=10, high_cnt_o=6, max_o=100, min_o=-100 on every pulse.
REQ-032 SHALL cover this case: the same square wave with sample_valid_i low every other cycle -> identical results at half the pulse rate.
REQ-033 SHALL cover this case: HYST=20 with a wave toggling between +10 and -10 -> no result_valid_o and locked_o stays 0.
REQ-034 SHALL cover this case: PER_WIDTH=4 with a constant +50 after lock -> timeout_o pulses after 15 samples, state SEEK, results unchanged.
REQ-035 SHALL cover this case: rst_n=0 for one cycle mid-window, then the square wave resumes -> outputs zero and the first result appears only after two new crossings.
REQ-036 SHALL cover this case: enable dropped mid-window and re-raised -> locked_o=0 within 1 cycle, then re-lock on the next crossing.

Source files
------------

// File: rtl/waveform_gen_pkg.sv
// Shared types and widths for the waveform generator / analyzer family.
// The analyzer reuses the generator's sample width so both ends agree on the sample format.
package waveform_gen_pkg;

    localparam int LUT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        MEASURE = 2'd2
    } ana_state_t;

    function automatic logic is_nonneg(input logic signed [LUT_WIDTH-1:0] s);
        return ~s[LUT_WIDTH-1];
    endfunction

endpackage

// File: rtl/waveform_analyzer_if.sv
// Sample stream in, per-cycle measurement results out, plus FSM debug taps.
interface waveform_analyzer_if #(
    parameter int PER_WIDTH = 16
);
    import waveform_gen_pkg::*;

    // sample_valid_i qualifies sample_i on a clk edge; there is no backpressure,
    // so every valid sample is consumed. result_valid_o / timeout_o are single-cycle strobes.
    logic signed [LUT_WIDTH-1:0] sample_i;
    logic                        sample_valid_i;

    logic [PER_WIDTH-1:0]        period_o;
    logic [PER_WIDTH-1:0]        high_cnt_o;
    logic signed [LUT_WIDTH-1:0] max_o;
    logic signed [LUT_WIDTH-1:0] min_o;
    logic                        result_valid_o;
    logic                        timeout_o;
    logic                        locked_o;

    ana_state_t                  state_o;
    logic                        below_o;

    modport master (
        output sample_i, sample_valid_i,
        input  period_o, high_cnt_o, max_o, min_o,
        input  result_valid_o, timeout_o, locked_o,
        input  state_o, below_o
    );

    modport slave (
        input  sample_i, sample_valid_i,
        output period_o, high_cnt_o, max_o, min_o,
        output result_valid_o, timeout_o, locked_o,
        output state_o, below_o
    );

endinterface

// File: rtl/waveform_analyzer_zc_detect.sv
// Rising zero-crossing detector with hysteresis: arms on a sample below -HYST,
// fires (combinationally) on the next accepted sample at or above +HYST.
module zc_detect
    import waveform_gen_pkg::*;
#(
    parameter int HYST = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clr,
    input  logic                        i_valid,
    input  logic signed [LUT_WIDTH-1:0] i_sample,
    output logic                        rise_o,
    output logic                        below_o
);

    logic signed [31:0] w_s_ext;
    logic               w_at_or_above;
    logic               w_under;
    logic               r_below;

    assign w_s_ext       = 32'(i_sample);
    assign w_at_or_above = (w_s_ext >= HYST);
    assign w_under       = (w_s_ext < -HYST);

    assign rise_o  = i_valid && !i_clr && r_below && w_at_or_above;
    assign below_o = r_below;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_below <= 1'b0;
        end else if (i_clr) begin
            r_below <= 1'b0;
        end else if (rise_o) begin
            r_below <= 1'b0;
        end else if (i_valid && w_under) begin
            r_below <= 1'b1;
        end
    end

endmodule

// File: rtl/waveform_analyzer.sv
// Measures period, high-sample count and peak values of a periodic signal between
// successive rising crossings; results are registered one cycle after each closing crossing.
module waveform_analyzer
    import waveform_gen_pkg::*;
#(
    parameter int PER_WIDTH = 16,
    parameter int HYST      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    waveform_analyzer_if.slave  bus
);

    localparam logic [PER_WIDTH-1:0] PER_ONE  = {{(PER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PER_WIDTH-1:0] PER_LAST = {{(PER_WIDTH-1){1'b1}}, 1'b0};

    ana_state_t                  r_state;
    ana_state_t                  w_next;

    logic signed [LUT_WIDTH-1:0] w_sample;
    logic                        w_nonneg;
    logic                        w_acc;
    logic                        w_clr;
    logic                        w_rise;
    logic                        w_below;

    logic                        w_load;
    logic                        w_accum;
    logic                        w_emit;
    logic                        w_timeout;

    logic [PER_WIDTH-1:0]        r_period;
    logic [PER_WIDTH-1:0]        r_high;
    logic signed [LUT_WIDTH-1:0] r_max;
    logic signed [LUT_WIDTH-1:0] r_min;

    logic [PER_WIDTH-1:0]        r_period_o;
    logic [PER_WIDTH-1:0]        r_high_o;
    logic signed [LUT_WIDTH-1:0] r_max_o;
    logic signed [LUT_WIDTH-1:0] r_min_o;
    logic                        r_result_valid;
    logic                        r_timeout;
    logic                        r_locked;

    assign w_sample = bus.sample_i;
    assign w_nonneg = is_nonneg(w_sample);
    assign w_acc    = enable && bus.sample_valid_i;
    // The detector stays disarmed whenever the analyzer is idle or being disabled.
    assign w_clr    = !enable || (r_state == IDLE);

    zc_detect #(
        .HYST     (HYST)
    ) u_zc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_valid  (bus.sample_valid_i),
        .i_sample (w_sample),
        .rise_o   (w_rise),
        .below_o  (w_below)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_accum   = 1'b0;
        w_emit    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_next = SEEK;
                end
            end
            SEEK: begin
                if (!enable) begin
                    w_next = IDLE;
                end else if (w_acc && w_rise) begin
                    w_next = MEASURE;
                    w_load = 1'b1;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    w_next = IDLE;
                end else if (w_acc) begin
                    if (w_rise) begin
                        w_emit = 1'b1;
                        w_load = 1'b1;
                    end else if (r_period == PER_LAST) begin
                        // This sample would bring the count to all-ones: give up on the window.
                        w_timeout = 1'b1;
                        w_next    = SEEK;
                    end else begin
                        w_accum = 1'b1;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_period       <= '0;
            r_high         <= '0;
            r_max          <= '0;
            r_min          <= '0;
            r_period_o     <= '0;
            r_high_o       <= '0;
            r_max_o        <= '0;
            r_min_o        <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_result_valid <= w_emit;
            r_timeout      <= w_timeout;
            r_locked       <= (w_next == MEASURE);

            if (w_emit) begin
                r_period_o <= r_period;
                r_high_o   <= r_high;
                r_max_o    <= r_max;
                r_min_o    <= r_min;
            end

            if (w_load) begin
                r_period <= PER_ONE;
                r_high   <= w_nonneg ? PER_ONE : '0;
                r_max    <= w_sample;
                r_min    <= w_sample;
            end else if (w_accum) begin
                r_period <= r_period + PER_ONE;
                r_high   <= r_high + (w_nonneg ? PER_ONE : '0);
                if (w_sample > r_max) begin
                    r_max <= w_sample;
                end
                if (w_sample < r_min) begin
                    r_min <= w_sample;
                end
            end else if (w_next != MEASURE) begin
                r_period <= '0;
                r_high   <= '0;
                r_max    <= '0;
                r_min    <= '0;
            end
        end
    end

    assign bus.period_o       = r_period_o;
    assign bus.high_cnt_o     = r_high_o;
    assign bus.max_o          = r_max_o;
    assign bus.min_o          = r_min_o;
    assign bus.result_valid_o = r_result_valid;
    assign bus.timeout_o      = r_timeout;
    assign bus.locked_o       = r_locked;
    assign bus.state_o        = r_state;
    assign bus.below_o        = w_below;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Bench for waveform_analyzer: three configurations driven one at a time against a
// sample-queue reference model (windows kept as sample lists, statistics computed on close).
module tb_waveform_analyzer;
    import waveform_gen_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        tb_en;
    logic                        tb_v;
    logic signed [LUT_WIDTH-1:0] tb_s;
    int                          sel;
    logic                        en0, en1, en2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    waveform_analyzer_if #(.PER_WIDTH(16)) if0 ();
    waveform_analyzer_if #(.PER_WIDTH(16)) if1 ();
    waveform_analyzer_if #(.PER_WIDTH(4))  if2 ();

    assign if0.sample_i = tb_s;
    assign if1.sample_i = tb_s;
    assign if2.sample_i = tb_s;
    assign if0.sample_valid_i = tb_v;
    assign if1.sample_valid_i = tb_v;
    assign if2.sample_valid_i = tb_v;
    assign en0 = tb_en && (sel == 0);
    assign en1 = tb_en && (sel == 1);
    assign en2 = tb_en && (sel == 2);

    waveform_analyzer #(.PER_WIDTH(16), .HYST(0))  dut0 (.clk(clk), .rst_n(rst_n), .enable(en0), .bus(if0));
    waveform_analyzer #(.PER_WIDTH(16), .HYST(20)) dut1 (.clk(clk), .rst_n(rst_n), .enable(en1), .bus(if1));
    waveform_analyzer #(.PER_WIDTH(4),  .HYST(0))  dut2 (.clk(clk), .rst_n(rst_n), .enable(en2), .bus(if2));

    // reference model state
    int                          m_hyst;
    int                          m_pw;
    bit                          m_active, m_locked, m_below, m_emit, m_to;
    logic signed [LUT_WIDTH-1:0] win_q[$];
    logic [47:0]                 exp_q[$];
    logic [47:0]                 m_held;

    // observations
    logic        o_rv, o_to, o_lk;
    ana_state_t  o_st;
    logic [47:0] o_res;
    int          rv_seen, to_seen, lk_seen, extra_rv;
    int          ph;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] pack(input int p, input int h, input int mx, input int mn);
        return {16'(p), 16'(h), 8'(mx), 8'(mn)};
    endfunction

    function automatic ana_state_t model_state();
        if (!m_active) return IDLE;
        if (m_locked)  return MEASURE;
        return SEEK;
    endfunction

    task automatic model_init(input int hyst, input int pw);
        m_hyst   = hyst;
        m_pw     = pw;
        m_active = 0;
        m_locked = 0;
        m_below  = 0;
        win_q.delete();
        m_held   = '0;
    endtask

    task automatic close_window();
        int cnt_hi = 0;
        int mx = int'(win_q[0]);
        int mn = int'(win_q[0]);
        foreach (win_q[i]) begin
            if (win_q[i] >= 0) cnt_hi++;
            if (int'(win_q[i]) > mx) mx = int'(win_q[i]);
            if (int'(win_q[i]) < mn) mn = int'(win_q[i]);
        end
        m_held = pack(win_q.size(), cnt_hi, mx, mn);
        exp_q.push_back(m_held);
        m_emit = 1;
    endtask

    task automatic model_step(input bit r, input bit en, input bit v, input logic signed [LUT_WIDTH-1:0] s);
        m_emit = 0;
        m_to   = 0;
        if (!r) begin
            model_init(m_hyst, m_pw);
        end else if (!en) begin
            m_active = 0;
            m_locked = 0;
            m_below  = 0;
            win_q.delete();
        end else if (!m_active) begin
            m_active = 1;
            m_below  = 0;
        end else if (v) begin
            if (m_below && int'(s) >= m_hyst) begin
                if (m_locked) close_window();
                win_q.delete();
                win_q.push_back(s);
                m_locked = 1;
                m_below  = 0;
            end else begin
                if (int'(s) < -m_hyst) m_below = 1;
                if (m_locked) begin
                    win_q.push_back(s);
                    if (win_q.size() == (1 << m_pw) - 1) begin
                        m_to     = 1;
                        m_locked = 0;
                        win_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic read_dut();
        case (sel)
            0: begin
                o_rv = if0.result_valid_o; o_to = if0.timeout_o; o_lk = if0.locked_o; o_st = if0.state_o;
                o_res = {if0.period_o, if0.high_cnt_o, if0.max_o, if0.min_o};
            end
            1: begin
                o_rv = if1.result_valid_o; o_to = if1.timeout_o; o_lk = if1.locked_o; o_st = if1.state_o;
                o_res = {if1.period_o, if1.high_cnt_o, if1.max_o, if1.min_o};
            end
            default: begin
                o_rv = if2.result_valid_o; o_to = if2.timeout_o; o_lk = if2.locked_o; o_st = if2.state_o;
                o_res = {12'd0, if2.period_o, 12'd0, if2.high_cnt_o, if2.max_o, if2.min_o};
            end
        endcase
    endtask

    // One clock: drive inputs, advance the model, sample the selected DUT #1 after the edge.
    task automatic cyc(input bit r, input bit en, input bit v, input logic signed [LUT_WIDTH-1:0] s);
        rst_n = r;
        tb_en = en;
        tb_v  = v;
        tb_s  = s;
        model_step(r, en, v, s);
        @(posedge clk);
        #1;
        read_dut();
        chk("result_valid", o_rv, m_emit);
        chk("timeout", o_to, m_to);
        chk("locked", o_lk, m_locked);
        chk("state", o_st, model_state());
        chk("held_outputs", o_res, m_held);
        if (o_rv) begin
            rv_seen++;
            if (exp_q.size() > 0) chk("scoreboard", o_res, exp_q.pop_front());
            else extra_rv++;
        end
        if (o_to) to_seen++;
        if (o_lk) lk_seen++;
    endtask

    // Square wave: 6 samples +100, 4 samples -100; alt inserts an invalid garbage cycle before each sample.
    task automatic sq_run(input int n, input bit alt);
        logic signed [LUT_WIDTH-1:0] g;
        for (int i = 0; i < n; i++) begin
            if (alt) begin
                g = 8'($urandom);
                cyc(1, 1, 0, g);
            end
            cyc(1, 1, 1, (ph < 6) ? 8'sd100 : -8'sd100);
            ph = (ph + 1) % 10;
        end
    endtask

    task automatic rand_run(input int n, input int amp, input int max_hi, input int max_lo,
                            input int p_en_drop, input int p_rst);
        int cnt = 0;
        int seg;
        int val;
        bit hi = 1;
        bit r, en, v;
        while (cnt < n) begin
            seg = hi ? int'($urandom_range(max_hi, 1)) : int'($urandom_range(max_lo, 1));
            for (int i = 0; i < seg && cnt < n; i++) begin
                val = hi ? int'($urandom_range(amp, 0)) : -int'($urandom_range(amp, 1));
                r   = (int'($urandom_range(99, 0)) >= p_rst);
                en  = (int'($urandom_range(99, 0)) >= p_en_drop);
                v   = ($urandom_range(3, 0) != 0);
                cyc(r, en, v, val[7:0]);
                cnt++;
            end
            hi = !hi;
        end
    endtask

    initial begin
        sel = 0; rst_n = 1'b0; tb_en = 1'b0; tb_v = 1'b0; tb_s = '0; ph = 0;
        extra_rv = 0; rv_seen = 0; to_seen = 0; lk_seen = 0;
        model_init(0, 16);
        cyc(0, 0, 0, 8'sd0);
        cyc(0, 0, 0, 8'sd0);
        chk("reset_outputs", o_res, 48'd0);
        chk("reset_state", o_st, IDLE);

        // Continuous square wave
        rv_seen = 0;
        sq_run(80, 0);
        chk("sq_count", rv_seen, 6);
        chk("sq_result", o_res, pack(10, 6, 100, -100));

        // Same wave, valid low every other cycle
        rv_seen = 0;
        sq_run(40, 1);
        chk("alt_count", rv_seen, 4);
        chk("alt_result", o_res, pack(10, 6, 100, -100));

        // Reset for one cycle mid-window
        sq_run(3, 0);
        cyc(0, 1, 1, 8'sd100);
        chk("rst_zero", o_res, 48'd0);
        chk("rst_unlocked", o_lk, 0);
        rv_seen = 0;
        sq_run(7, 0);
        sq_run(10, 0);
        chk("rst_no_early", rv_seen, 0);
        sq_run(20, 0);
        chk("rst_two_results", rv_seen, 2);
        chk("rst_result", o_res, pack(10, 6, 100, -100));

        // Enable dropped mid-window, then re-raised
        sq_run(3, 0);
        cyc(1, 0, 1, 8'sd100);
        chk("en_drop_unlock", o_lk, 0);
        lk_seen = 0;
        sq_run(7, 0);
        chk("en_wait", lk_seen, 0);
        sq_run(1, 0);
        chk("en_relock", o_lk, 1);
        sq_run(19, 0);

        rand_run(600, 127, 9, 9, 2, 1);

        // Hysteresis configuration
        sel = 1;
        model_init(20, 16);
        rv_seen = 0; lk_seen = 0;
        for (int i = 0; i < 40; i++) cyc(1, 1, 1, (i % 2 == 1) ? -8'sd10 : 8'sd10);
        chk("hyst_no_result", rv_seen, 0);
        chk("hyst_unlocked", lk_seen, 0);
        ph = 0;
        sq_run(40, 0);
        chk("hyst_sq_count", rv_seen, 2);
        chk("hyst_sq_result", o_res, pack(10, 6, 100, -100));
        rand_run(400, 40, 6, 6, 2, 1);

        // Narrow period counter: timeout
        sel = 2;
        model_init(0, 4);
        ph = 0; rv_seen = 0;
        sq_run(30, 0);
        chk("pw4_count", rv_seen, 1);
        to_seen = 0;
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 8'sd50);
        chk("to_count", to_seen, 1);
        chk("to_state", o_st, SEEK);
        chk("to_held", o_res, pack(10, 6, 100, -100));
        rand_run(600, 127, 25, 6, 2, 1);

        chk("scoreboard_drain", exp_q.size(), 0);
        chk("extra_results", extra_rv, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
